// File: rtl/spiker_sample_ctrl.sv
// Sampling scheduler: paces core-output captures into the result writer, batches them for software.
// Optional overrun detection is compiled in with SPIKER_SAMPLE_CTRL_OVERRUN_EN.
module spiker_sample_ctrl #(
  parameter int CNT_W     = 16,
  parameter int PERIOD_W  = 16,
  parameter int BATCH_LEN = 15
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                test_mode_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [CNT_W-1:0]    n_samples_i,
  input  logic                core_valid_i,
  input  logic                writer_ready_i,
  input  logic                batch_ack_i,
  output logic                sample_o,
  output logic                busy_o,
  output logic                batch_done_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    sample_count_o,
  output logic                overrun_o
);

  localparam int BW = $clog2(BATCH_LEN + 1);

  typedef enum logic [2:0] {IDLE, WAIT, ARM, SAMPLE, HOLD} state_t;

  state_t              state;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] timer;
  logic [CNT_W-1:0]    n_samples_q;
  logic [BW-1:0]       batch_cnt;
  logic [CNT_W-1:0]    count_nxt;
  logic [BW-1:0]       batch_nxt;
  logic [PERIOD_W-1:0] reload;

  assign count_nxt = sample_count_o + CNT_W'(1);
  assign batch_nxt = batch_cnt + BW'(1);
  assign reload    = test_mode_i ? '0 : period_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      timer          <= '0;
      period_q       <= '0;
      n_samples_q    <= '0;
      batch_cnt      <= '0;
      sample_o       <= 1'b0;
      busy_o         <= 1'b0;
      batch_done_o   <= 1'b0;
      done_o         <= 1'b0;
      sample_count_o <= '0;
    end else begin
      sample_o <= 1'b0;
      done_o   <= 1'b0;
      if (batch_ack_i)
        batch_done_o <= 1'b0;
      // A capture in flight is always counted, even when stop_i aborts the run in the same cycle.
      if (state == SAMPLE) begin
        sample_count_o <= count_nxt;
        if (batch_nxt == BW'(BATCH_LEN)) begin
          batch_cnt    <= '0;
          batch_done_o <= 1'b1;
        end else begin
          batch_cnt <= batch_nxt;
        end
      end
      if (state != IDLE && stop_i) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start_i) begin
            period_q       <= period_i;
            n_samples_q    <= n_samples_i;
            sample_count_o <= '0;
            batch_cnt      <= '0;
            timer          <= test_mode_i ? '0 : period_i;
            busy_o         <= 1'b1;
            state          <= WAIT;
          end
          WAIT: begin
            if (timer == '0) state <= ARM;
            else             timer <= timer - PERIOD_W'(1);
          end
          ARM: if (core_valid_i && writer_ready_i) begin
            sample_o <= 1'b1;
            state    <= SAMPLE;
          end
          SAMPLE: begin
            if (n_samples_q != '0 && count_nxt == n_samples_q) begin
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= IDLE;
            end else if (batch_nxt == BW'(BATCH_LEN)) begin
              state <= HOLD;
            end else begin
              timer <= reload;
              state <= WAIT;
            end
          end
          HOLD: if (batch_ack_i) begin
            timer <= reload;
            state <= WAIT;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SPIKER_SAMPLE_CTRL_OVERRUN_EN
  // Core data was on offer but could not be taken: writer stalled in ARM, or software batch pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      overrun_o <= 1'b0;
    else if (state == IDLE && start_i)
      overrun_o <= 1'b0;
    else if (core_valid_i && (state == HOLD || (state == ARM && !writer_ready_i)))
      overrun_o <= 1'b1;
  end
`else
  assign overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_spiker_sample_ctrl.sv
// Bench for spiker_sample_ctrl: directed scenarios plus randomized runs against an event-level model.
module tb_spiker_sample_ctrl;
  localparam int CW = 16;
  localparam int PW = 16;
  localparam int BL = 15;
  localparam int L  = 1024;
`ifdef SPIKER_SAMPLE_CTRL_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          test_mode_i = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic [PW-1:0] period_i = '0;
  logic [CW-1:0] n_samples_i = '0;
  logic          core_valid_i = 1'b0;
  logic          writer_ready_i = 1'b0;
  logic          batch_ack_i = 1'b0;
  logic          sample_o, busy_o, batch_done_o, done_o, overrun_o;
  logic [CW-1:0] sample_count_o;

  int checks = 0;
  int errors = 0;
  int obs_s[$];
  int obs_d[$];

  bit v_arr[L];
  bit r_arr[L];
  bit e_smp[L];
  bit e_done[L];
  bit e_busy[L];
  bit e_bd[L];
  bit e_ack[L];
  int e_cnt[L];

  spiker_sample_ctrl #(.CNT_W(CW), .PERIOD_W(PW), .BATCH_LEN(BL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .start_i(start_i),
    .stop_i(stop_i), .period_i(period_i), .n_samples_i(n_samples_i),
    .core_valid_i(core_valid_i), .writer_ready_i(writer_ready_i), .batch_ack_i(batch_ack_i),
    .sample_o(sample_o), .busy_o(busy_o), .batch_done_o(batch_done_o), .done_o(done_o),
    .sample_count_o(sample_count_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Advance into cycle k: pulses from cycle k-1 end, outputs of cycle k are recorded.
  task automatic tick_obs(input int k);
    tick();
    start_i = 1'b0;
    stop_i = 1'b0;
    batch_ack_i = 1'b0;
    if (sample_o) obs_s.push_back(k);
    if (done_o) obs_d.push_back(k);
  endtask

  task automatic kick(input int p, input int n, input bit tm);
    period_i = PW'(p);
    n_samples_i = CW'(n);
    test_mode_i = tm;
    start_i = 1'b1;
    obs_s.delete();
    obs_d.delete();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) tick();
    checks++;
    if ({sample_o, busy_o, batch_done_o, done_o, overrun_o} !== 5'b0 || sample_count_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got s=%b b=%b bd=%b d=%b o=%b cnt=%0d required all 0",
               sample_o, busy_o, batch_done_o, done_o, overrun_o, sample_count_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit busy16;
    int cnt16;
    core_valid_i = 1'b1;
    writer_ready_i = 1'b1;
    kick(2, 3, 1'b0);
    busy16 = 1'b1;
    cnt16 = -1;
    for (int k = 1; k <= 20; k++) begin
      tick_obs(k);
      if (k == 1) begin
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy_t1: got %b required 1", busy_o); end
      end
      if (k == 16) begin busy16 = busy_o; cnt16 = int'(sample_count_o); end
    end
    checks++;
    if (obs_s.size() != 3 || obs_s[0] != 5 || obs_s[1] != 10 || obs_s[2] != 15) begin
      errors++;
      $display("FAIL basic_sample_times: got %p required 5,10,15", obs_s);
    end
    checks++;
    if (obs_d.size() != 1 || obs_d[0] != 16) begin
      errors++; $display("FAIL basic_done: got %p required 16", obs_d);
    end
    checks++;
    if (busy16 !== 1'b0 || cnt16 != 3) begin
      errors++; $display("FAIL basic_end_state: got busy=%b cnt=%0d required busy=0 cnt=3", busy16, cnt16);
    end
  endtask

  task automatic test_start_ignored();
    kick(2, 3, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick_obs(k);
      if (k == 3) begin start_i = 1'b1; period_i = '0; n_samples_i = CW'(1); end
    end
    checks++;
    if (obs_s.size() != 3 || obs_s[0] != 5 || obs_s[1] != 10 || obs_s[2] != 15 ||
        obs_d.size() != 1 || obs_d[0] != 16) begin
      errors++;
      $display("FAIL start_ignored: got samples %p done %p required 5,10,15 done 16", obs_s, obs_d);
    end
  endtask

  task automatic test_test_mode();
    kick(100, 3, 1'b1);
    for (int k = 1; k <= 14; k++) tick_obs(k);
    test_mode_i = 1'b0;
    checks++;
    if (obs_s.size() != 3 || obs_s[0] != 3 || obs_s[1] != 6 || obs_s[2] != 9) begin
      errors++; $display("FAIL test_mode_spacing: got %p required 3,6,9", obs_s);
    end
  endtask

  task automatic test_batch_hold();
    kick(0, 0, 1'b0);
    for (int k = 1; k <= 60; k++) tick_obs(k);
    checks++;
    if (obs_s.size() != BL || batch_done_o !== 1'b1 || busy_o !== 1'b1 || sample_count_o !== CW'(BL)) begin
      errors++;
      $display("FAIL batch_hold: got pulses=%0d bd=%b busy=%b cnt=%0d required %0d,1,1,%0d",
               obs_s.size(), batch_done_o, busy_o, sample_count_o, BL, BL);
    end
    obs_s.delete();
    batch_ack_i = 1'b1;
    tick_obs(61);
    checks++;
    if (batch_done_o !== 1'b0) begin errors++; $display("FAIL batch_ack_clear: got %b required 0", batch_done_o); end
    tick_obs(62);
    tick_obs(63);
    checks++;
    if (obs_s.size() != 1 || obs_s[0] != 63) begin
      errors++; $display("FAIL batch_resume: got %p required 63", obs_s);
    end
    checks++;
    if (overrun_o !== OVR_EN) begin errors++; $display("FAIL hold_overrun: got %b required %b", overrun_o, OVR_EN); end
    stop_i = 1'b1;
    tick_obs(64);
    tick_obs(65);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL batch_stop: got busy=%b required 0", busy_o); end
  endtask

  task automatic test_ready_stall();
    core_valid_i = 1'b1;
    writer_ready_i = 1'b0;
    kick(0, 1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      tick_obs(k);
      if (k == 12) writer_ready_i = 1'b1;
    end
    checks++;
    if (obs_s.size() != 1 || obs_s[0] != 13) begin errors++; $display("FAIL stall_sample: got %p required 13", obs_s); end
    checks++;
    if (overrun_o !== OVR_EN) begin errors++; $display("FAIL stall_overrun: got %b required %b", overrun_o, OVR_EN); end
    checks++;
    if (obs_d.size() != 1 || obs_d[0] != 14 || sample_count_o !== CW'(1)) begin
      errors++; $display("FAIL stall_done: got %p cnt=%0d required 14 cnt=1", obs_d, sample_count_o);
    end
  endtask

  task automatic test_stop();
    core_valid_i = 1'b1;
    writer_ready_i = 1'b1;
    kick(3, 0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick_obs(k);
      if (k == 14) stop_i = 1'b1;
      if (k == 15) begin
        checks++;
        if (busy_o !== 1'b0 || sample_count_o !== CW'(2)) begin
          errors++; $display("FAIL stop_state: got busy=%b cnt=%0d required 0,2", busy_o, sample_count_o);
        end
      end
    end
    checks++;
    if (obs_s.size() != 2 || obs_d.size() != 0) begin
      errors++; $display("FAIL stop_pulses: got samples %p done %p required 6,12 and none", obs_s, obs_d);
    end
    kick(3, 0, 1'b0);
    tick_obs(1);
    checks++;
    if (sample_count_o !== '0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL restart_clear: got cnt=%0d busy=%b required 0,1", sample_count_o, busy_o);
    end
    stop_i = 1'b1;
    tick_obs(2);
  endtask

  task automatic test_reset_hold();
    core_valid_i = 1'b1;
    writer_ready_i = 1'b1;
    kick(0, 0, 1'b0);
    for (int k = 1; k <= 50; k++) tick_obs(k);
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({sample_o, busy_o, batch_done_o, done_o, overrun_o} !== 5'b0 || sample_count_o !== '0) begin
      errors++;
      $display("FAIL reset_mid_hold: got s=%b b=%b bd=%b d=%b o=%b cnt=%0d required all 0",
               sample_o, busy_o, batch_done_o, done_o, overrun_o, sample_count_o);
    end
    core_valid_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  // Event-level model: after a start, capture or ack the FSM becomes eligible for capture
  // P+2 cycles later, captures on the first valid&ready cycle, and sample_o follows one cycle on.
  task automatic test_random(input int p, input int n, input int d);
    int e, c, s, cnt, bc, a, last, kmax;
    bit ovr;
    for (int i = 0; i < L; i++) begin
      v_arr[i] = ($urandom_range(3) != 0);
      r_arr[i] = ($urandom_range(3) != 0);
      e_smp[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_bd[i] = 0; e_ack[i] = 0; e_cnt[i] = 0;
    end
    e = p + 2; cnt = 0; bc = 0; ovr = 0; last = L - 8;
    while (cnt < n && e < L - 16) begin
      c = e;
      while (c < L - 16 && !(v_arr[c] && r_arr[c])) begin
        if (v_arr[c]) ovr = 1;
        c++;
      end
      s = c + 1;
      e_smp[s] = 1; cnt++; bc++;
      for (int x = s + 1; x < L; x++) e_cnt[x] = cnt;
      if (cnt == n) begin
        e_done[s + 1] = 1;
        last = s + 1;
        if (bc == BL) for (int x = s + 1; x < L; x++) e_bd[x] = 1;
        break;
      end
      if (bc == BL) begin
        bc = 0;
        a = s + 1 + d;
        for (int x = s + 1; x <= a; x++) begin
          e_bd[x] = 1;
          if (v_arr[x]) ovr = 1;
        end
        e_ack[a] = 1;
        e = a + p + 2;
      end else begin
        e = s + p + 2;
      end
    end
    for (int x = 1; x < last; x++) e_busy[x] = 1;
    kmax = (last + 3 < L) ? last + 3 : L - 1;

    kick(p, n, 1'b0);
    core_valid_i = v_arr[0];
    writer_ready_i = r_arr[0];
    for (int k = 1; k <= kmax; k++) begin
      tick_obs(k);
      checks++;
      if (sample_o !== e_smp[k] || done_o !== e_done[k] || busy_o !== e_busy[k] ||
          batch_done_o !== e_bd[k] || sample_count_o !== CW'(e_cnt[k])) begin
        errors++;
        $display("FAIL rand_cycle %0d (P=%0d n=%0d): got s=%b d=%b b=%b bd=%b cnt=%0d required s=%b d=%b b=%b bd=%b cnt=%0d",
                 k, p, n, sample_o, done_o, busy_o, batch_done_o, sample_count_o,
                 e_smp[k], e_done[k], e_busy[k], e_bd[k], e_cnt[k]);
      end
      core_valid_i = v_arr[k];
      writer_ready_i = r_arr[k];
      batch_ack_i = e_ack[k];
    end
    checks++;
    if (overrun_o !== (OVR_EN & ovr)) begin
      errors++; $display("FAIL rand_overrun (P=%0d n=%0d): got %b required %b", p, n, overrun_o, OVR_EN & ovr);
    end
    core_valid_i = 1'b0;
    batch_ack_i = 1'b1;
    tick_obs(kmax + 1);
    tick_obs(kmax + 2);
    checks++;
    if (batch_done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rand_idle_ack: got bd=%b busy=%b required 0,0", batch_done_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_test_mode();
    test_batch_hold();
    test_ready_stall();
    test_stop();
    test_reset_hold();
    for (int i = 0; i < 6; i++) begin
      test_random(int'($urandom_range(3)),
                  (i == 0) ? BL : (i == 1) ? 2 * BL : int'($urandom_range(40, 1)),
                  int'($urandom_range(4)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spiker_sample_ctrl.md
# spiker_sample_ctrl

Sampling scheduler for the spiker adapter datapath. It decides when the spiker core output is captured into the result writer. It paces captures with a programmable period, gates them on core-valid and writer-ready, and stops after a programmed number of samples. It also holds off after every batch of BATCH_LEN captures until software acknowledges the batch through the register file. It sits between the adapter register file (configuration, start/stop, acknowledge) and the writer's sample/ready handshake.

## Interface
Parameters:
- CNT_W, 16, width of sample-count configuration and counter
- PERIOD_W, 16, width of inter-sample period configuration
- BATCH_LEN, 15, captures per software batch (≥1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- test_mode_i  in  1  forces period to 0 when high
- start_i  in  1  one-cycle start pulse; ignored unless IDLE
- stop_i  in  1  one-cycle abort pulse
- period_i  in  PERIOD_W  idle cycles between captures; latched at start
- n_samples_i  in  CNT_W  captures per run, 0 = continuous; latched at start
- core_valid_i  in  1  spiker core output valid
- writer_ready_i  in  1  writer can accept a capture
- batch_ack_i  in  1  one-cycle pulse: software has read the batch
- sample_o  out  1  one-cycle capture pulse to the writer; registered
- busy_o  out  1  high in every state except IDLE
- batch_done_o  out  1  level; BATCH_LEN captures pending software read
- done_o  out  1  one-cycle pulse when n_samples captures have completed
- sample_count_o  out  CNT_W  captures since last start
- overrun_o  out  1  sticky; core data offered but not captured

## Operation
- States: IDLE, WAIT, ARM, SAMPLE, HOLD.
- IDLE + start_i:
  - latch period_i and n_samples_i;
  - clear sample_count, batch counter and overrun_o;
  - load timer with period (0 if test_mode_i);
  - go to WAIT.
- WAIT:
  - timer==0 → ARM;
  - otherwise decrement the timer.
- ARM: core_valid_i && writer_ready_i → SAMPLE.
- SAMPLE:
  - sample_o=1;
  - sample_count += 1 (wraps at 2^CNT_W);
  - batch counter += 1.
- Exit from SAMPLE, in priority order:
  1. n_samples≠0 and new count == n_samples → pulse done_o, go to IDLE.
  2. Otherwise, if batch counter == BATCH_LEN → clear the batch counter, set batch_done_o, go to HOLD.
  3. Otherwise → reload the timer, go to WAIT.
- Run end and batch boundary coincide (case 1 when the batch counter reaches BATCH_LEN): done_o pulses and batch_done_o also sets. Software must still acknowledge the final batch.
- HOLD + batch_ack_i: clear batch_done_o, reload the timer, go to WAIT.
- batch_done_o:
  - cleared only by batch_ack_i or reset;
  - batch_ack_i while batch_done_o is low has no effect.
- stop_i in any non-IDLE state:
  - next state IDLE; no done_o;
  - batch_done_o and sample_count_o are retained;
  - a sample_o already asserted in that cycle still completes and is counted;
  - stop_i has priority over every other transition.
- start_i while busy_o=1 is ignored. stop_i and start_i together in IDLE: start wins.
- Overrun: set when core_valid_i=1 in HOLD, or in ARM with writer_ready_i=0. It stays set until the next accepted start_i.
- Reset mid-run: immediately IDLE; all state cleared.

## Timing
- Reset values: sample_o=0, busy_o=0, batch_done_o=0, done_o=0, sample_count_o=0, overrun_o=0; state IDLE; timer 0.
- start_i at cycle t → busy_o=1 at t+1.
- Earliest sample_o = t+P+3 (P = latched period): WAIT P+1 cycles, then ARM, then SAMPLE.
- Steady-state minimum capture spacing is P+3 cycles.
- Capture latency: ARM condition true in cycle c → sample_o in c+1.
- Timing of count/status updates:
  - sample_count_o and batch_done_o update in the cycle after sample_o;
  - done_o pulses in that same cycle;
  - busy_o falls in that same cycle when the run ends.
- batch_ack_i at cycle a (in HOLD) → batch_done_o=0 at a+1.

## Configuration
- SPIKER_SAMPLE_CTRL_OVERRUN_EN defined: overrun detection logic as described; overrun_o is live.
- Not defined: no overrun logic is instantiated; overrun_o tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- period=2, n_samples=3, core_valid and writer_ready held high, start at cycle 0:
  - sample_o at cycles 5, 10, 15;
  - done_o at 16, busy_o=0 at 16, sample_count_o=3.
- n_samples=0, BATCH_LEN=15, period=0, no ack:
  - exactly 15 sample_o pulses, then batch_done_o=1 and FSM stays in HOLD;
  - ack → batch_done_o=0 next cycle and the 16th capture follows 3 cycles later.
- writer_ready low for 10 cycles in ARM with core_valid high:
  - no sample_o until ready returns;
  - overrun_o=1 with the macro, 0 without.
- stop_i in WAIT after 2 captures:
  - IDLE next cycle, sample_count_o=2, no done_o;
  - a later start_i clears the count to 0.
- start_i during a run: ignored, latched period unchanged.
- test_mode_i=1 with period=100: captures spaced 3 cycles.
- Reset asserted mid-HOLD: all outputs 0 asynchronously.
